// File: rtl/transconv_stream.sv
// transconv_stream: streaming stride-2 3x3 transposed convolution (2x upsampler).
// Input arrives row by row (channel fastest). Each beat scatters nine MACs into three
// row accumulators. After a full input row, the two finished output rows are drained.
module transconv_stream #(
   parameter int unsigned DW    = 8,
   parameter int unsigned WW    = 8,
   parameter int unsigned C_IN  = 2,
   parameter int unsigned MAX_W = 64,
   parameter int unsigned AW    = 24,
   parameter int unsigned OW    = 20,
   parameter int unsigned RELU  = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [$clog2(MAX_W):0] width_i,
   input  logic [15:0]            height_i,
   input  logic [C_IN*9*WW-1:0]   weights_i,
   input  logic [WW-1:0]          bias_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [DW-1:0]          in_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [OW-1:0]          out_data_o,
   output logic                   busy_o,
   output logic                   frame_done_o
);

   localparam int unsigned CW  = $clog2(MAX_W) + 1;
   localparam int unsigned NB  = 2 * MAX_W;
   localparam int unsigned BW  = $clog2(NB);
   localparam int unsigned OCW = CW + 2;
   localparam int unsigned CHW = (C_IN > 1) ? $clog2(C_IN) : 1;
   localparam int unsigned PW  = DW + WW;
   localparam logic signed [AW-1:0] SAT_MAX = AW'({(OW-1){1'b1}});
   localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

   state_e               state_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [OW-1:0]        out_data_q;
   logic                 busy_q;
   logic                 frame_done_q;
   logic [CW-1:0]        width_q;
   logic [15:0]          height_q;
   logic [15:0]          r_q;
   logic [CW-1:0]        c_q;
   logic [CHW-1:0]       ch_q;
   logic [OCW-1:0]       out_idx_q;
   logic signed [AW-1:0] row_a_q [NB];
   logic signed [AW-1:0] row_b_q [NB];
   logic signed [AW-1:0] carry_q [NB];

   logic                 last_col_c;
   logic                 last_ch_c;
   logic                 last_out_c;
   logic                 last_row_c;
   logic [OCW-1:0]       two_w_c;
   logic [BW-1:0]        mac_col_d [3];
   logic signed [AW-1:0] mac_d [3][3];
   logic signed [WW-1:0] w_t;
   logic signed [PW-1:0] p_t;
   logic signed [AW-1:0] old_t;
   logic signed [AW-1:0] first_acc_d;
   logic [OCW-1:0]       nxt_idx_d;
   logic signed [AW-1:0] nxt_acc_d;
   logic                 clr_is_a_c;
   logic [BW-1:0]        clr_idx_d;

   // Bias, optional ReLU, then clamp to the signed OW range.
   function automatic logic [OW-1:0] sat_fn(input logic signed [AW-1:0] acc,
                                            input logic [WW-1:0] b);
      logic signed [AW-1:0] v;
      v = acc + AW'($signed(b));
      if (RELU != 0 && v[AW-1]) v = '0;
      if (v > SAT_MAX) return SAT_MAX[OW-1:0];
      if (v < SAT_MIN) return SAT_MIN[OW-1:0];
      return v[OW-1:0];
   endfunction

   // Beat MACs, row/column bookkeeping and drain addressing.
   always_comb begin
      w_t   = '0;
      p_t   = '0;
      old_t = '0;
      last_col_c = (c_q == width_q - CW'(1));
      last_ch_c  = (ch_q == CHW'(C_IN - 1));
      two_w_c    = OCW'({width_q, 1'b0});
      last_out_c = (out_idx_q == OCW'({width_q, 2'b00}) - OCW'(1));
      last_row_c = (r_q == height_q - 16'd1);
      for (int j = 0; j < 3; j++) begin
         mac_col_d[j] = BW'({c_q, 1'b0}) + BW'(j);
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            w_t = $signed(weights_i[(int'(ch_q) * 9 + i * 3 + j) * WW +: WW]);
            p_t = PW'($signed(in_data_i)) * PW'(w_t);
            if (i == 0)      old_t = row_a_q[mac_col_d[j]];
            else if (i == 1) old_t = row_b_q[mac_col_d[j]];
            else             old_t = carry_q[mac_col_d[j]];
            mac_d[i][j] = old_t + AW'(p_t);
         end
      end
      // Column 0 of row A is still being updated by the final beat only when W == 1.
      first_acc_d = (width_q == CW'(1)) ? mac_d[0][0] : row_a_q[0];
      nxt_idx_d   = out_idx_q + OCW'(1);
      nxt_acc_d   = (nxt_idx_d < two_w_c) ? row_a_q[BW'(nxt_idx_d)]
                                          : row_b_q[BW'(nxt_idx_d - two_w_c)];
      clr_is_a_c  = (out_idx_q < two_w_c);
      clr_idx_d   = clr_is_a_c ? BW'(out_idx_q) : BW'(out_idx_q - two_w_c);
   end

   // Frame FSM with the accumulator buffers and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         width_q      <= '0;
         height_q     <= '0;
         r_q          <= '0;
         c_q          <= '0;
         ch_q         <= '0;
         out_idx_q    <= '0;
         for (int k = 0; k < NB; k++) begin
            row_a_q[k] <= '0;
            row_b_q[k] <= '0;
            carry_q[k] <= '0;
         end
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && width_i != '0 && height_i != '0) begin
                  width_q    <= width_i;
                  height_q   <= height_i;
                  r_q        <= '0;
                  c_q        <= '0;
                  ch_q       <= '0;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
                  state_q    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (in_valid_i && in_ready_q) begin
                  for (int j = 0; j < 3; j++) begin
                     if (j != 2 || !last_col_c) begin
                        row_a_q[mac_col_d[j]] <= mac_d[0][j];
                        row_b_q[mac_col_d[j]] <= mac_d[1][j];
                        carry_q[mac_col_d[j]] <= mac_d[2][j];
                     end
                  end
                  if (last_ch_c) begin
                     ch_q <= '0;
                     if (last_col_c) begin
                        c_q         <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= '0;
                        out_data_q  <= sat_fn(first_acc_d, bias_i);
                        state_q     <= S_DRAIN;
                     end else begin
                        c_q <= c_q + CW'(1);
                     end
                  end else begin
                     ch_q <= ch_q + CHW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready_i) begin
                  if (clr_is_a_c) row_a_q[clr_idx_d] <= '0;
                  else            row_b_q[clr_idx_d] <= '0;
                  if (last_out_c) begin
                     out_valid_q <= 1'b0;
                     for (int k = 0; k < NB; k++) begin
                        row_a_q[k] <= last_row_c ? '0 : carry_q[k];
                        carry_q[k] <= '0;
                     end
                     if (last_row_c) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= S_DONE;
                     end else begin
                        r_q        <= r_q + 16'd1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_LOAD;
                     end
                  end else begin
                     out_idx_q  <= nxt_idx_d;
                     out_data_q <= sat_fn(nxt_acc_d, bias_i);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready_o   = in_ready_q;
   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_transconv_stream.sv
// Directed bench for transconv_stream: three parameter variants share one stimulus bus.
`timescale 1ns/1ps
module tb_transconv_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   int           sel;
   logic         start;
   logic [6:0]   width;
   logic [15:0]  height;
   logic [71:0]  w1;
   logic [143:0] w2;
   logic [7:0]   bias;
   logic         in_valid;
   logic [7:0]   in_data;
   logic         out_ready;

   logic         rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c;
   logic         busy_a, busy_b, busy_c, fd_a, fd_b, fd_c;
   logic [19:0]  od_a, od_c;
   logic [11:0]  od_b;
   logic         start_a, start_b, start_c, iv_a, iv_b, iv_c;

   logic         cur_ready, cur_valid, cur_busy, cur_fd;
   int           cur_data;

   assign start_a = start && (sel == 0);
   assign start_b = start && (sel == 1);
   assign start_c = start && (sel == 2);
   assign iv_a    = in_valid && (sel == 0);
   assign iv_b    = in_valid && (sel == 1);
   assign iv_c    = in_valid && (sel == 2);

   transconv_stream #(.C_IN(2)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .width_i(width), .height_i(height),
      .weights_i(w2), .bias_i(bias), .in_valid_i(iv_a), .in_ready_o(rdy_a), .in_data_i(in_data),
      .out_valid_o(ov_a), .out_ready_i(out_ready), .out_data_o(od_a), .busy_o(busy_a),
      .frame_done_o(fd_a));

   transconv_stream #(.C_IN(1), .OW(12)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .width_i(width), .height_i(height),
      .weights_i(w1), .bias_i(bias), .in_valid_i(iv_b), .in_ready_o(rdy_b), .in_data_i(in_data),
      .out_valid_o(ov_b), .out_ready_i(out_ready), .out_data_o(od_b), .busy_o(busy_b),
      .frame_done_o(fd_b));

   transconv_stream #(.C_IN(1), .RELU(1)) u_dut_c (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .width_i(width), .height_i(height),
      .weights_i(w1), .bias_i(bias), .in_valid_i(iv_c), .in_ready_o(rdy_c), .in_data_i(in_data),
      .out_valid_o(ov_c), .out_ready_i(out_ready), .out_data_o(od_c), .busy_o(busy_c),
      .frame_done_o(fd_c));

   // Route the selected instance to the observation signals.
   always_comb begin
      cur_ready = rdy_a;
      cur_valid = ov_a;
      cur_busy  = busy_a;
      cur_fd    = fd_a;
      cur_data  = int'($signed(od_a));
      if (sel == 1) begin
         cur_ready = rdy_b;
         cur_valid = ov_b;
         cur_busy  = busy_b;
         cur_fd    = fd_b;
         cur_data  = int'($signed(od_b));
      end else if (sel == 2) begin
         cur_ready = rdy_c;
         cur_valid = ov_c;
         cur_busy  = busy_c;
         cur_fd    = fd_c;
         cur_data  = int'($signed(od_c));
      end
   end

   int n_pass = 0;
   int n_checks = 0;
   int xq[$];
   int got[$];
   int ref_q[$];
   int fd_seen, bad_ready, first_v, row0_end;
   int xs[4][4][2];
   int wv[2][3][3];
   int b5;
   int e_t1[4] = '{5, 10, 20, 25};
   int e_t2[8] = '{3, 3, 6, 3, 3, 3, 6, 3};

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   function automatic int got_at(input int i);
      return (i < got.size()) ? got[i] : -999999;
   endfunction

   // Reference: direct scatter formula, cropped by the output window, bias, clamp to 20 bits.
   function automatic int model(input int y, input int x);
      int acc;
      acc = b5;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int ch = 0; ch < 2; ch++)
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     if (2 * r + i == y && 2 * c + j == x) acc += xs[r][c][ch] * wv[ch][i][j];
      if (acc > 524287) acc = 524287;
      if (acc < -524288) acc = -524288;
      return acc;
   endfunction

   // Start a frame, stream xq in and collect outputs until frame_done (or abort/timeout).
   task automatic run_frame(input int w, input int h, input bit stall, input int abort_at);
      int k, cyc, row0_beats;
      got.delete();
      fd_seen = 0; bad_ready = 0; first_v = -1; row0_end = -1;
      k = 0; cyc = 0;
      row0_beats = xq.size() / h;
      @(negedge clk);
      width = 7'(w); height = 16'(h); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < 4000) begin
         if (cur_fd) begin
            fd_seen = 1;
            break;
         end
         if (abort_at > 0 && k == abort_at) break;
         out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
         in_valid  = (k < xq.size()) && (!stall || (cyc % 3) != 2);
         in_data   = (k < xq.size()) ? 8'(xq[k]) : 8'h00;
         if (cur_valid && out_ready) got.push_back(cur_data);
         if (cur_valid && first_v < 0) first_v = cyc;
         if (cur_valid && cur_ready) bad_ready++;
         if (in_valid && cur_ready) begin
            k++;
            if (k == row0_beats) row0_end = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; sel = 0; start = 1'b0; width = '0; height = '0;
      w1 = '0; w2 = '0; bias = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      // Reset state
      check("rst_valid", int'(ov_a) + int'(ov_b) + int'(ov_c), 0);
      check("rst_ready", int'(rdy_a) + int'(rdy_b) + int'(rdy_c), 0);
      check("rst_busy", int'(busy_a) + int'(busy_b) + int'(busy_c), 0);
      check("rst_done", int'(fd_a) + int'(fd_b) + int'(fd_c), 0);
      check("rst_data", int'(od_a) + int'(od_b) + int'(od_c), 0);
      rst_n = 1'b1;

      // Zero-sized frames are ignored
      sel = 0; width = 7'd0; height = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0; @(negedge clk);
      check("zero_width_busy", int'(cur_busy), 0);
      width = 7'd2; height = 16'd0; start = 1'b1;
      @(negedge clk); start = 1'b0; @(negedge clk);
      check("zero_height_busy", int'(cur_busy), 0);

      // Test 1: single pixel, raster weights 1..9
      sel = 1; bias = 8'd0;
      for (int t = 0; t < 9; t++) w1[t*8 +: 8] = 8'(t + 1);
      xq.delete(); xq.push_back(5);
      run_frame(1, 1, 1'b0, 0);
      check("t1_frame_done", fd_seen, 1);
      check("t1_busy_after", int'(cur_busy), 0);
      check("t1_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t1_out%0d", i), got_at(i), e_t1[i]);
      @(negedge clk);
      check("t1_done_pulse", int'(cur_fd), 0);

      // Test 3: saturation at OW=12
      w1 = {9{8'd127}};
      xq.delete(); xq.push_back(127);
      run_frame(1, 1, 1'b0, 0);
      check("t3_pos_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t3_pos%0d", i), got_at(i), 2047);
      xq.delete(); xq.push_back(-128);
      run_frame(1, 1, 1'b0, 0);
      check("t3_neg_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t3_neg%0d", i), got_at(i), -2048);

      // Test 4: ReLU variant
      sel = 2; w1 = {9{8'd1}}; bias = 8'd0;
      xq.delete(); xq.push_back(-3);
      run_frame(1, 1, 1'b0, 0);
      check("t4_neg_count", got.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t4_zero%0d", i), got_at(i), 0);
      bias = 8'd5;
      xq.delete(); xq.push_back(-1);
      run_frame(1, 1, 1'b0, 0);
      for (int i = 0; i < 4; i++) check($sformatf("t4_bias%0d", i), got_at(i), 4);

      // Test 2: two channels, W=2, H=1, overlap in column 2
      sel = 0; w2 = {18{8'd1}}; bias = 8'd0;
      xq.delete(); xq.push_back(1); xq.push_back(2); xq.push_back(1); xq.push_back(2);
      run_frame(2, 1, 1'b0, 0);
      check("t2_frame_done", fd_seen, 1);
      check("t2_count", got.size(), 8);
      for (int i = 0; i < 8; i++) check($sformatf("t2_out%0d", i), got_at(i), e_t2[i]);
      check("t2_latency", first_v - row0_end, 1);

      // Test 5: 4x4 random frame, plain run vs model, then stalled run vs plain run
      b5 = int'($urandom_range(0, 255)) - 128;
      bias = 8'(b5);
      for (int ch = 0; ch < 2; ch++)
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
               wv[ch][i][j] = int'($urandom_range(0, 255)) - 128;
               w2[(ch*9 + i*3 + j)*8 +: 8] = 8'(wv[ch][i][j]);
            end
      xq.delete();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            for (int ch = 0; ch < 2; ch++) begin
               xs[r][c][ch] = int'($urandom_range(0, 255)) - 128;
               xq.push_back(xs[r][c][ch]);
            end
      run_frame(4, 4, 1'b0, 0);
      check("t5_frame_done", fd_seen, 1);
      check("t5_count", got.size(), 64);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            check($sformatf("t5_y%0d_x%0d", y, x), got_at(y*8 + x), model(y, x));
      check("t5_ready_in_drain", bad_ready, 0);
      ref_q = got;
      run_frame(4, 4, 1'b1, 0);
      check("t5s_frame_done", fd_seen, 1);
      check("t5s_count", got.size(), 64);
      for (int i = 0; i < 64; i++)
         check($sformatf("t5s_out%0d", i), got_at(i), (i < ref_q.size()) ? ref_q[i] : -1);
      check("t5s_ready_in_drain", bad_ready, 0);

      // Test 6: reset during row 1, then a clean frame
      bias = 8'd0; w2 = {18{8'd1}};
      xq.delete();
      for (int t = 0; t < 4; t++) begin xq.push_back(1); xq.push_back(2); end
      run_frame(2, 2, 1'b0, 5);
      check("t6_row0_count", got.size(), 8);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("t6_rst_valid", int'(cur_valid), 0);
      check("t6_rst_ready", int'(cur_ready), 0);
      check("t6_rst_busy", int'(cur_busy), 0);
      check("t6_rst_data", cur_data, 0);
      rst_n = 1'b1;
      xq.delete(); xq.push_back(1); xq.push_back(2); xq.push_back(1); xq.push_back(2);
      run_frame(2, 1, 1'b0, 0);
      check("t6_frame_done", fd_seen, 1);
      check("t6_count", got.size(), 8);
      for (int i = 0; i < 8; i++) check($sformatf("t6_out%0d", i), got_at(i), e_t2[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
